robot_nav_ctrl: RTL and testbench

- Motion controller that sequences the robot's drive datapath from the 16-bit distance sensor sample stream.
- Classifies each valid distance sample against near/far thresholds and runs an obstacle-avoidance FSM: cruise, slow, stop, turn.
- Drives registered left/right wheel speed and direction commands to the motor driver.
- Sits between the sensor interface (`dist_v`) and the motor PWM stage inside the robot top level.

---
 rtl/robot_nav_ctrl.sv | 153 +++++++++++++++
 tb/tb_robot_nav_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/robot_nav_ctrl.sv
// ---------------------------------------------------------------------------
// robot_nav_ctrl
//   Obstacle-avoidance motion controller. Classifies each valid distance
//   sample against NEAR/FAR thresholds and sequences IDLE/FWD/SLOW/STOP/TURN.
//   Wheel commands are registered and decoded from the next state, so they
//   change on the same edge as the state register.
//
// Ports
//   clk        : system clock, rising edge
//   rstn       : asynchronous active-low reset
//   en         : run enable, 0 forces IDLE
//   dist_v     : distance sample (unsigned, DW bits)
//   dist_valid : single-cycle qualifier for dist_v
//   speed_l/r  : wheel speed commands
//   dir_l/r    : wheel directions (0=forward, 1=reverse)
//   state_o    : current state code (IDLE=0 FWD=1 SLOW=2 STOP=3 TURN=4)
//   obst_cnt   : saturating count of STOP entries
// ---------------------------------------------------------------------------
module robot_nav_ctrl #(
    parameter int             DW       = 16,
    parameter logic [DW-1:0]  NEAR     = 16'd200,
    parameter logic [DW-1:0]  FAR      = 16'd500,
    parameter int             STOP_CYC = 4,
    parameter int             TURN_CYC = 8,
    parameter logic [7:0]     SPD_FAST = 8'd200,
    parameter logic [7:0]     SPD_SLOW = 8'd80
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [DW-1:0] dist_v,
    input  logic          dist_valid,
    output logic [7:0]    speed_l,
    output logic [7:0]    speed_r,
    output logic          dir_l,
    output logic          dir_r,
    output logic [2:0]    state_o,
    output logic [7:0]    obst_cnt
);

    localparam int MAXC = (STOP_CYC > TURN_CYC) ? STOP_CYC : TURN_CYC;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0] STOP_LD = TW'(STOP_CYC - 1);
    localparam logic [TW-1:0] TURN_LD = TW'(TURN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FWD  = 3'd1,
        S_SLOW = 3'd2,
        S_STOP = 3'd3,
        S_TURN = 3'd4
    } state_t;

    state_t        r_state, w_next;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [DW-1:0] r_last_dist;
    logic [7:0]    r_obst;
    logic          w_stop_entry;
    logic [DW-1:0] w_turn_dist;
    logic [7:0]    w_spd_l, w_spd_r;
    logic          w_dir_r;

    // Next-state / timer logic
    always_comb begin
        w_next       = r_state;
        w_timer_nxt  = r_timer;
        w_stop_entry = 1'b0;
        // A sample arriving on the decision cycle overrides the stored one.
        w_turn_dist  = dist_valid ? dist_v : r_last_dist;
        if (!en) begin
            w_next      = S_IDLE;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_FWD;
                S_FWD, S_SLOW: begin
                    if (dist_valid) begin
                        if (dist_v < NEAR) begin
                            w_next       = S_STOP;
                            w_timer_nxt  = STOP_LD;
                            w_stop_entry = 1'b1;
                        end else if (dist_v >= FAR) begin
                            w_next = S_FWD;
                        end else begin
                            w_next = S_SLOW;
                        end
                    end
                end
                S_STOP: begin
                    if (r_timer == '0) begin
                        w_next      = S_TURN;
                        w_timer_nxt = TURN_LD;
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
                S_TURN: begin
                    if (r_timer == '0) begin
                        if (w_turn_dist >= NEAR) w_next = S_FWD;
                        else                     w_timer_nxt = TURN_LD;
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
                default: begin
                    w_next      = S_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so commands track the state register
    always_comb begin
        w_spd_l = 8'd0;
        w_spd_r = 8'd0;
        w_dir_r = 1'b0;
        case (w_next)
            S_FWD:  begin w_spd_l = SPD_FAST; w_spd_r = SPD_FAST; end
            S_SLOW: begin w_spd_l = SPD_SLOW; w_spd_r = SPD_SLOW; end
            S_TURN: begin w_spd_l = SPD_SLOW; w_spd_r = SPD_SLOW; w_dir_r = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_last_dist <= '0;
            r_obst      <= 8'd0;
            speed_l     <= 8'd0;
            speed_r     <= 8'd0;
            dir_l       <= 1'b0;
            dir_r       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_nxt;
            speed_l <= w_spd_l;
            speed_r <= w_spd_r;
            dir_l   <= 1'b0;
            dir_r   <= w_dir_r;
            if (dist_valid && (r_state != S_IDLE))
                r_last_dist <= dist_v;
            if (w_stop_entry && (r_obst != 8'hFF))
                r_obst <= r_obst + 8'd1;
        end
    end

    assign state_o  = r_state;
    assign obst_cnt = r_obst;

endmodule

// File: tb/tb_robot_nav_ctrl.sv
module tb_robot_nav_ctrl;

    localparam int STOP_CYC = 4;
    localparam int TURN_CYC = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [15:0] dist_v;
    logic        dist_valid;
    logic [7:0]  speed_l, speed_r, obst_cnt;
    logic        dir_l, dir_r;
    logic [2:0]  state_o;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: mode names the behaviour, left = cycles still owed
    // to the current STOP or turn attempt.
    int m_mode = 0;
    int m_left = 0;
    int m_last = 0;
    int m_cnt  = 0;

    robot_nav_ctrl dut (
        .clk(clk), .rstn(rstn), .en(en), .dist_v(dist_v), .dist_valid(dist_valid),
        .speed_l(speed_l), .speed_r(speed_r), .dir_l(dir_l), .dir_r(dir_r),
        .state_o(state_o), .obst_cnt(obst_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_left = 0; m_last = 0; m_cnt = 0;
    endfunction

    function automatic void model_step(input bit e, input bit v, input int d);
        int prev = m_mode;
        if (!e) begin
            m_mode = 0; m_left = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (v) begin
                if (d < 200) begin
                    m_mode = 3; m_left = STOP_CYC;
                    if (m_cnt < 255) m_cnt++;
                end else if (d < 500) m_mode = 2;
                else m_mode = 1;
            end
        end else if (m_mode == 3) begin
            m_left--;
            if (m_left == 0) begin m_mode = 4; m_left = TURN_CYC; end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if ((v ? d : m_last) >= 200) m_mode = 1;
                else m_left = TURN_CYC;
            end
        end
        if (v && prev != 0) m_last = d;
    endfunction

    function automatic logic [28:0] model_vec();
        logic [7:0] spd;
        case (m_mode)
            1: spd = 8'd200;
            2, 4: spd = 8'd80;
            default: spd = 8'd0;
        endcase
        return {3'(m_mode), spd, spd, 1'b0, 1'(m_mode == 4), 8'(m_cnt)};
    endfunction

    // Drive one cycle, advance the model, compare everything after the edge.
    task automatic step(input bit e, input bit v, input int d);
        en = e; dist_valid = v; dist_v = 16'(d);
        model_step(e, v, d);
        @(posedge clk); #1;
        dist_valid = 1'b0;
        chk("cycle", {state_o, speed_l, speed_r, dir_l, dir_r, obst_cnt}, model_vec());
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; dist_v = '0; dist_valid = 1'b0;
        model_reset();
        #12;
        chk("rst_state", state_o, 0);
        chk("rst_out", {speed_l, speed_r, dir_l, dir_r, obst_cnt}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Cruise and threshold boundaries
        step(1, 0, 0);     chk("fwd_spd", {speed_l, speed_r}, {8'd200, 8'd200});
        step(1, 1, 600);   chk("fwd600", state_o, 1);
        step(1, 1, 500);   chk("far_bound", state_o, 1);
        step(1, 1, 499);   chk("slow_spd", {state_o, speed_l, speed_r}, {3'd2, 8'd80, 8'd80});
        step(1, 1, 200);   chk("near_bound", state_o, 2);

        // Obstacle: STOP for 4 cycles, then TURN attempts
        step(1, 1, 199);   chk("stop_cnt", {state_o, speed_l, obst_cnt}, {3'd3, 8'd0, 8'd1});
        idle_steps(3);     chk("stop_last", state_o, 3);
        step(1, 0, 0);     chk("turn_entry", {state_o, speed_l, speed_r, dir_l, dir_r}, {3'd4, 8'd80, 8'd80, 1'b0, 1'b1});
        idle_steps(7);
        step(1, 0, 0);     chk("turn_repeat", state_o, 4);
        step(1, 1, 800);
        idle_steps(6);     chk("turn_wait", state_o, 4);
        step(1, 0, 0);     chk("turn_exit", state_o, 1);

        // Bypass on the decision cycle
        step(1, 1, 50); idle_steps(3); step(1, 0, 0); idle_steps(7);
        step(1, 1, 300);   chk("bypass_fwd", state_o, 1);
        step(1, 1, 50); idle_steps(3); step(1, 0, 0); idle_steps(7);
        step(1, 1, 100);   chk("bypass_turn", state_o, 4);

        // Enable drop in SLOW
        step(0, 0, 0); step(1, 0, 0); step(1, 1, 300);
        step(0, 0, 0);     chk("en_slow", {state_o, speed_l, obst_cnt}, {3'd0, 8'd0, 8'd3});
        step(1, 0, 0);     chk("reen", state_o, 1);

        // Enable drop in STOP
        step(1, 1, 10);
        step(0, 0, 0);     chk("en_stop", {state_o, speed_l, obst_cnt}, {3'd0, 8'd0, 8'd4});
        step(1, 0, 0);

        // Asynchronous reset mid-TURN
        step(1, 1, 10); idle_steps(3); step(1, 0, 0); idle_steps(2);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst", {state_o, speed_l, speed_r, dir_r, obst_cnt}, 0);
        model_reset();
        #2 rstn = 1'b1;
        step(1, 0, 0); step(1, 0, 0);
        chk("post_rst", {state_o, speed_l, speed_r}, {3'd1, 8'd200, 8'd200});

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int d;
            case ($urandom_range(0, 4))
                0: d = $urandom_range(0, 199);
                1: d = $urandom_range(198, 202);
                2: d = $urandom_range(498, 502);
                3: d = $urandom_range(200, 499);
                default: d = $urandom_range(0, 65535);
            endcase
            step($urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0, d);
        end

        // Saturation of the obstacle counter
        step(0, 0, 0); step(1, 0, 0);
        for (int i = 0; i < 260; i++) begin
            step(1, 1, 5); step(0, 0, 0); step(1, 0, 0);
        end
        chk("obst_sat", obst_cnt, 255);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
